instr_fetch_queue: RTL
======================

// Module: instr_fetch_queue
// PURPOSE
// Fetch front end between a variable-latency instruction memory and the IF/ID pipeline register.
// Owns the fetch PC and issues in-order word requests. Buffers up to DEPTH returned instructions with their PCs.
// Presents one instruction per cycle to IF/ID, honouring stall (hold) and flush/redirect (discard + restart).
// PARAMETERS
// DEPTH     4             queue entries; also the cap on buffered + live in-flight requests
// RESET_PC  32'h00000000  fetch PC after reset
// PORTS
// clk_i          in   1   clock, all state on rising edge
// rst_i          in   1   asynchronous, active-low reset
// start_i        in   1   fetch enable; low = issue nothing new, still absorb/drain
// imem_req_o     out  1   request offer this cycle (combinational, may drop any cycle)
// imem_addr_o    out  32  word address of request (= fetch PC)
// imem_gnt_i     in   1   request accepted; counts only when imem_req_o high
// imem_rvalid_i  in   1   in-order response valid (>=1 cycle after gnt)
// imem_rdata_i   in   32  response instruction
// instr_valid_o  out  1   queue head valid
// instr_o        out  32  head instruction; 32'h00000013 (NOP) when !instr_valid_o
// pc_o           out  32  PC of head; 0 when !instr_valid_o
// stall_i        in   1   IF/ID hold; pop = instr_valid_o && !stall_i && !flush_i
// flush_i        in   1   redirect: discard queue and in-flight responses
// flush_pc_i     in   32  new fetch PC, sampled when flush_i high
// BEHAVIOUR
// - Reset values: fetch_pc = resp_pc = RESET_PC; count = outstanding = discard = 0.
//   Reset outputs: imem_req_o = 0, instr_valid_o = 0, instr_o = NOP, pc_o = 0.
// - Counters: count (0..DEPTH) and outstanding/discard (0..DEPTH), all $clog2(DEPTH+1) bits.
//   outstanding = granted, not yet returned, including the responses to be discarded.
// - imem_req_o = start_i && !flush_i && (count + outstanding - discard) < DEPTH.
// - Grant (req && gnt): outstanding++, fetch_pc += 4; wraps 32'hFFFFFFFC -> 0.
// - Response: outstanding--.
//   If discard > 0: discard--, data dropped.
//   Else: push {resp_pc, rdata}, resp_pc += 4 (same wrap).
// - Grant and response in the same cycle: outstanding unchanged.
// - Push while full is impossible by the credit rule; flag it as an assertion failure.
// - Pop: head advances. Push+pop in the same cycle: count unchanged, both legal at full/empty boundaries.
// - No bypass: a response at cycle t is visible on instr_o at t+1 at the earliest.
// - Flush at cycle t (overrides stall, push, pop and grant):
//   next cycle count = 0, fetch_pc = resp_pc = flush_pc_i, discard = outstanding - imem_rvalid_i.
//   A response arriving at t is dropped.
//   First request to flush_pc_i is offered at t+1.
//   A flush while discard > 0 is allowed (recomputed by the same formula).
// - start_i low: no requests; in-flight responses still enqueued; queue drains through pops.
// - stall_i high: head, instr_o and pc_o hold stable; pushes continue until full.
// - Reset mid-operation clears all state asynchronously.
//   The memory must be reset in the same domain, so no stale responses arrive after reset.
// STRUCTURE
// - Shared package fetch_pkg: NOP_INSTR = 32'h00000013, PC_STEP = 4, fetch entry struct {pc[31:0], instr[31:0]}.
// - Sub-module fetch_fifo: synchronous circular FIFO with DEPTH entries of 64 bits.
//   Ports: push, pop, clear, count; pointers wrap mod DEPTH; registered storage.
//   Top level holds PC/credit/discard logic only.
// TESTING
// 1) Reset, start_i=1, 1-cycle memory, no stall.
//    -> requests 0x0,0x4,0x8...; from cycle 3 instr_valid_o steady, pc_o increments by 4 each cycle.
// 2) stall_i held 10 cycles.
//    -> 4 entries buffered, imem_req_o=0 with 0 outstanding; head unchanged.
//    Release -> 4 back-to-back pops, no gap.
// 3) 3-cycle memory latency, flush_i with flush_pc_i=0x100 and 2 outstanding.
//    -> both late responses dropped; next valid pc_o=0x100.
// 4) flush_i in the same cycle as imem_rvalid_i and a push at full.
//    -> response dropped; count=0 next cycle; discard = outstanding-1.
// 5) start_i low mid-stream.
//    -> no new req; remaining in-flight delivered in order; then instr_valid_o=0, instr_o=NOP.
// 6) flush_pc_i=0xFFFFFFF8.
//    -> pc_o sequence FFFFFFF8, FFFFFFFC, 00000000.
//    Async rst_i low mid-burst -> outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetched {pc, instr} entries with push, pop and clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         clear_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The credit scheme upstream must never let a response land in a full queue.
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push_i && !pop_i && !clear_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues credit-limited requests and
// buffers in-order responses for IF/ID, with flush/redirect support.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i
);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count;
  logic [CW:0]   in_use;
  logic          grant, push, pop;
  fetch_entry_t  push_entry, head;

  // Responses already destined for the bin do not hold a queue slot.
  assign in_use     = {1'b0, count} + {1'b0, outstanding_q} - {1'b0, discard_q};
  assign imem_req_o = rst_i && start_i && !flush_i && (in_use < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc_q;

  assign grant      = imem_req_o && imem_gnt_i;
  assign push       = imem_rvalid_i && !flush_i && (discard_q == '0);
  assign pop        = instr_valid_o && !stall_i && !flush_i;
  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata_i};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (flush_i) begin
      fetch_pc_d    = flush_pc_i;
      resp_pc_d     = flush_pc_i;
      outstanding_d = outstanding_q - CW'(imem_rvalid_i);
      discard_d     = outstanding_q - CW'(imem_rvalid_i);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + PC_STEP;
      case ({grant, imem_rvalid_i})
        2'b10:   outstanding_d = outstanding_q + CW'(1);
        2'b01:   outstanding_d = outstanding_q - CW'(1);
        default: outstanding_d = outstanding_q;
      endcase
      if (imem_rvalid_i) begin
        if (discard_q != '0) discard_d = discard_q - CW'(1);
        else                 resp_pc_d = resp_pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .clear_i     (flush_i),
    .head_o      (head),
    .count_o     (count)
  );

  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? head.instr : NOP_INSTR;
  assign pc_o          = instr_valid_o ? head.pc    : 32'h0;

endmodule
